// File: rtl/fcl_fp_pkg.sv
// Shared types and constants for the fcl_fp engine and its layer scheduler.
package fcl_fp_pkg;
    localparam int PARALLEL_NUM = 4;
    localparam int ACC_WIDTH    = 32;
    localparam int WAW          = 12;
    localparam int MAX_NEURON   = 1024;
    localparam int MAX_LAYERS   = 8;
    localparam int ENGINE_LAT   = 1;
    localparam int NW           = $clog2(MAX_NEURON + 1);
    localparam int LW           = $clog2(MAX_LAYERS);
    localparam int SW           = $clog2(ACC_WIDTH);
    localparam int DW           = (ENGINE_LAT > 1) ? $clog2(ENGINE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ACC,
        S_DRAIN,
        S_WB,
        S_DONE
    } sched_state_t;

    typedef struct packed {
        logic [NW-1:0] in_num;
        logic [NW-1:0] out_num;
        logic [SW-1:0] shift;
    } layer_cfg_t;

    // Number of PARALLEL_NUM-wide output groups; widened so out_num+3 cannot wrap.
    function automatic logic [NW-1:0] group_count(input logic [NW-1:0] out_num);
        logic [NW:0] t;
        t = {1'b0, out_num} + (NW+1)'(PARALLEL_NUM - 1);
        return NW'(t / (NW+1)'(PARALLEL_NUM));
    endfunction
endpackage

// File: rtl/fcl_fp_layer_sched_if.sv
// Host/config, weight-read and engine/buffer bus of the layer scheduler.
// FCL_SCHED_PERF_EN adds the perf_cycles/perf_stalls counters.
interface fcl_fp_layer_sched_if;
    import fcl_fp_pkg::*;

    logic            cfg_we;
    logic [LW-1:0]   cfg_idx;
    logic [NW-1:0]   cfg_in_num;
    logic [NW-1:0]   cfg_out_num;
    logic [SW-1:0]   cfg_shift;
    logic [LW:0]     num_layers;
    logic            start;
    logic            busy;
    logic            done;
    logic            w_req;
    logic [WAW-1:0]  w_addr;
    logic            w_vld;
    logic            mac_run;
    logic            mac_en;
    logic [SW-1:0]   shift;
    logic [NW-1:0]   rd_addr;
    logic            rd_bank;
    logic            wb_en;
    logic [NW-1:0]   wb_addr;
    logic            wb_bank;
`ifdef FCL_SCHED_PERF_EN
    logic [31:0]     perf_cycles;
    logic [31:0]     perf_stalls;

    modport master (
        input  cfg_we, cfg_idx, cfg_in_num, cfg_out_num, cfg_shift, num_layers, start, w_vld,
        output busy, done, w_req, w_addr, mac_run, mac_en, shift, rd_addr, rd_bank,
               wb_en, wb_addr, wb_bank, perf_cycles, perf_stalls
    );
    modport slave (
        output cfg_we, cfg_idx, cfg_in_num, cfg_out_num, cfg_shift, num_layers, start, w_vld,
        input  busy, done, w_req, w_addr, mac_run, mac_en, shift, rd_addr, rd_bank,
               wb_en, wb_addr, wb_bank, perf_cycles, perf_stalls
    );
`else
    modport master (
        input  cfg_we, cfg_idx, cfg_in_num, cfg_out_num, cfg_shift, num_layers, start, w_vld,
        output busy, done, w_req, w_addr, mac_run, mac_en, shift, rd_addr, rd_bank,
               wb_en, wb_addr, wb_bank
    );
    modport slave (
        output cfg_we, cfg_idx, cfg_in_num, cfg_out_num, cfg_shift, num_layers, start, w_vld,
        input  busy, done, w_req, w_addr, mac_run, mac_en, shift, rd_addr, rd_bank,
               wb_en, wb_addr, wb_bank
    );
`endif
endinterface

// File: rtl/fcl_fp_sched_cfg.sv
// Per-layer configuration table: one write port, combinational read of the active layer.
module fcl_fp_sched_cfg
    import fcl_fp_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [LW-1:0] wr_idx,
    input  layer_cfg_t    wr_data,
    input  logic [LW-1:0] rd_idx,
    output layer_cfg_t    rd_data
);
    layer_cfg_t cfg_q [MAX_LAYERS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LAYERS; i++) cfg_q[i] <= '0;
        end else if (we) begin
            cfg_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = cfg_q[rd_idx];
endmodule

// File: rtl/fcl_fp_layer_sched.sv
// Layer/group/input sequencer for one fcl_fp engine.
// Optional FCL_SCHED_PERF_EN adds saturating busy-cycle and stall counters.
//
// state   | meaning
// IDLE    | waiting for start
// CLR     | clear engine accumulators, load layer shift
// ACC     | stream in_num weight words, one per w_vld
// DRAIN   | wait ENGINE_LAT cycles for engine output
// WB      | capture output group, pick next group/layer
// DONE    | one-cycle done pulse
module fcl_fp_layer_sched
    import fcl_fp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    fcl_fp_layer_sched_if.master bus
);
    sched_state_t   state;
    logic [LW:0]    layers_q;
    logic [LW-1:0]  layer;
    logic [NW-1:0]  grp;
    logic [NW-1:0]  in_cnt;
    logic [DW-1:0]  drain_cnt;
    logic [WAW-1:0] w_addr_q;
    logic [SW-1:0]  shift_q;
    logic [NW-1:0]  wb_addr_q;
    logic           busy_q, done_q, w_req_q, mac_run_q, rd_bank_q, wb_en_q, wb_bank_q;

    layer_cfg_t     wr_cfg, cur;
    logic [NW-1:0]  n_grp, grp_nxt;
    logic [LW:0]    layer_nxt;
    logic           start_ok;

    assign wr_cfg    = '{in_num: bus.cfg_in_num, out_num: bus.cfg_out_num, shift: bus.cfg_shift};
    assign n_grp     = group_count(cur.out_num);
    assign grp_nxt   = grp + NW'(1);
    assign layer_nxt = {1'b0, layer} + (LW+1)'(1);
    assign start_ok  = (state == S_IDLE) && bus.start && (bus.num_layers != '0);

    // Table is frozen while a run is in flight.
    fcl_fp_sched_cfg u_cfg (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.cfg_we & ~busy_q),
        .wr_idx  (bus.cfg_idx),
        .wr_data (wr_cfg),
        .rd_idx  (layer),
        .rd_data (cur)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            layers_q  <= '0;
            layer     <= '0;
            grp       <= '0;
            in_cnt    <= '0;
            drain_cnt <= '0;
            w_addr_q  <= '0;
            shift_q   <= '0;
            wb_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            w_req_q   <= 1'b0;
            mac_run_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_bank_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            wb_en_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        layers_q  <= bus.num_layers;
                        layer     <= '0;
                        grp       <= '0;
                        in_cnt    <= '0;
                        w_addr_q  <= '0;
                        rd_bank_q <= 1'b0;
                        busy_q    <= 1'b1;
                        mac_run_q <= 1'b0;
                        state     <= S_CLR;
                    end else if (bus.start) begin
                        done_q <= 1'b1;
                    end
                end
                S_CLR: begin
                    shift_q   <= cur.shift;
                    mac_run_q <= 1'b1;
                    if (cur.in_num == '0) begin
                        drain_cnt <= DW'(ENGINE_LAT - 1);
                        state     <= S_DRAIN;
                    end else begin
                        w_req_q <= 1'b1;
                        state   <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (bus.w_vld) begin
                        in_cnt   <= in_cnt + NW'(1);
                        w_addr_q <= w_addr_q + WAW'(1);
                        if (in_cnt == cur.in_num - NW'(1)) begin
                            w_req_q   <= 1'b0;
                            drain_cnt <= DW'(ENGINE_LAT - 1);
                            state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0) begin
                        wb_en_q   <= 1'b1;
                        wb_addr_q <= grp;
                        wb_bank_q <= ~rd_bank_q;
                        state     <= S_WB;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                S_WB: begin
                    in_cnt    <= '0;
                    mac_run_q <= 1'b0;
                    if (grp_nxt < n_grp) begin
                        grp   <= grp_nxt;
                        state <= S_CLR;
                    end else if (layer_nxt < layers_q) begin
                        layer     <= layer_nxt[LW-1:0];
                        grp       <= '0;
                        rd_bank_q <= ~rd_bank_q;
                        state     <= S_CLR;
                    end else begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.w_req   = w_req_q;
    assign bus.w_addr  = w_addr_q;
    assign bus.mac_run = mac_run_q;
    assign bus.mac_en  = w_req_q & bus.w_vld;
    assign bus.shift   = shift_q;
    assign bus.rd_addr = in_cnt;
    assign bus.rd_bank = rd_bank_q;
    assign bus.wb_en   = wb_en_q;
    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_bank = wb_bank_q;

`ifdef FCL_SCHED_PERF_EN
    logic [31:0] perf_cycles_q, perf_stalls_q;

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (busy_q && perf_cycles_q != '1)
                perf_cycles_q <= perf_cycles_q + 32'd1;
            if (state == S_ACC && !bus.w_vld && perf_stalls_q != '1)
                perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign bus.perf_cycles = perf_cycles_q;
    assign bus.perf_stalls = perf_stalls_q;
`endif
endmodule

// File: tb/tb_fcl_fp_layer_sched.sv
// Scoreboard bench for fcl_fp_layer_sched: expected write-backs queued per run, popped on wb_en.
module tb_fcl_fp_layer_sched;
    import fcl_fp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fcl_fp_layer_sched_if bus ();
    fcl_fp_layer_sched dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int addr;
        int bank;
        int shift;
    } wb_exp_t;

    wb_exp_t sb[$];
    wb_exp_t mon_e;

    int checks = 0;
    int errors = 0;

    int sh_in  [MAX_LAYERS];
    int sh_out [MAX_LAYERS];
    int sh_sh  [MAX_LAYERS];

    int n_wb, n_done, n_wreq, n_macen, n_busy, n_stall, n_toggle;
    int cyc = 0, last_wb_cyc, done_cyc;
    int exp_rd, exp_wa;
    int vld_mode = 0;
    logic prev_bank = 1'b0, prev_busy = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_wb = 0; n_done = 0; n_wreq = 0; n_macen = 0; n_busy = 0; n_stall = 0; n_toggle = 0;
        last_wb_cyc = 0; done_cyc = 0; exp_rd = 0; exp_wa = 0;
    endtask

    task automatic cfg_write(input int idx, input int in_n, input int out_n, input int sh, input bit upd);
        bus.cfg_we      = 1'b1;
        bus.cfg_idx     = LW'(idx);
        bus.cfg_in_num  = NW'(in_n);
        bus.cfg_out_num = NW'(out_n);
        bus.cfg_shift   = SW'(sh);
        tick(1);
        bus.cfg_we = 1'b0;
        if (upd) begin
            sh_in[idx] = in_n; sh_out[idx] = out_n; sh_sh[idx] = sh;
        end
    endtask

    task automatic start_run(input int nl);
        clear_stats();
        bus.num_layers = (LW+1)'(nl);
        bus.start      = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic expect_run(input int nl, output int busy_exp, output int mac_exp);
        busy_exp = 0;
        mac_exp  = 0;
        for (int l = 0; l < nl; l++) begin
            int ng;
            ng = (sh_out[l] + PARALLEL_NUM - 1) / PARALLEL_NUM;
            if (ng == 0) ng = 1;
            for (int g = 0; g < ng; g++) begin
                wb_exp_t e;
                e.addr  = g;
                e.bank  = (l % 2 == 0) ? 1 : 0;
                e.shift = sh_sh[l];
                sb.push_back(e);
            end
            busy_exp += ng * (2 + sh_in[l] + ENGINE_LAT);
            mac_exp  += ng * sh_in[l];
        end
    endtask

    task automatic wait_done(input int limit, input string tag);
        int k;
        k = 0;
        while (n_done == 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, "_done_seen"}, 64'(n_done > 0), 64'd1);
        repeat (3) @(negedge clk);
        check_val({tag, "_done_once"}, 64'(n_done), 64'd1);
        check_val({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        tick(1);
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_busy"},    64'(bus.busy),    64'd0);
        check_val({tag, "_done"},    64'(bus.done),    64'd0);
        check_val({tag, "_w_req"},   64'(bus.w_req),   64'd0);
        check_val({tag, "_w_addr"},  64'(bus.w_addr),  64'd0);
        check_val({tag, "_mac_run"}, 64'(bus.mac_run), 64'd0);
        check_val({tag, "_mac_en"},  64'(bus.mac_en),  64'd0);
        check_val({tag, "_shift"},   64'(bus.shift),   64'd0);
        check_val({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
        check_val({tag, "_rd_bank"}, 64'(bus.rd_bank), 64'd0);
        check_val({tag, "_wb_en"},   64'(bus.wb_en),   64'd0);
        check_val({tag, "_wb_addr"}, 64'(bus.wb_addr), 64'd0);
        check_val({tag, "_wb_bank"}, 64'(bus.wb_bank), 64'd0);
    endtask

    // Weight-valid pattern: steady high, or alternating every cycle.
    initial begin
        bus.w_vld = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.w_vld = (vld_mode == 0) ? 1'b1 : ~bus.w_vld;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (bus.busy) n_busy++;
            if (bus.done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (bus.busy && prev_busy && bus.rd_bank !== prev_bank) n_toggle++;
            prev_bank = bus.rd_bank;
            prev_busy = bus.busy;
            if (bus.mac_en) n_macen++;
            if (bus.w_req) begin
                n_wreq++;
                check_val("rd_addr", 64'(bus.rd_addr), 64'(exp_rd));
                check_val("w_addr", 64'(bus.w_addr), 64'(exp_wa));
                if (bus.w_vld) begin
                    exp_rd++;
                    exp_wa++;
                end else begin
                    n_stall++;
                end
            end else begin
                exp_rd = 0;
            end
            if (bus.wb_en) begin
                n_wb++;
                last_wb_cyc = cyc;
                check_val("wb_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check_val("wb_addr",  64'(bus.wb_addr), 64'(mon_e.addr));
                    check_val("wb_bank",  64'(bus.wb_bank), 64'(mon_e.bank));
                    check_val("wb_shift", 64'(bus.shift),   64'(mon_e.shift));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_exp, mac_exp, wb_before, k;

        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_in_num = '0; bus.cfg_out_num = '0;
        bus.cfg_shift = '0; bus.num_layers = '0; bus.start = 1'b0;
        for (int i = 0; i < MAX_LAYERS; i++) begin
            sh_in[i] = 0; sh_out[i] = 0; sh_sh[i] = 0;
        end
        clear_stats();

        repeat (3) @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1 rst = 1'b0;
        tick(1);

        // 784-16-16-16-10, no stalls
        cfg_write(0, 784, 16, 5, 1);
        cfg_write(1, 16, 16, 6, 1);
        cfg_write(2, 16, 16, 7, 1);
        cfg_write(3, 16, 10, 8, 1);
        expect_run(4, busy_exp, mac_exp);
        start_run(4);
        @(negedge clk);
        check_val("start_busy",    64'(bus.busy),    64'd1);
        check_val("start_mac_run", 64'(bus.mac_run), 64'd0);
        check_val("start_w_req0",  64'(bus.w_req),   64'd0);
        @(negedge clk);
        check_val("start_w_req1",  64'(bus.w_req),   64'd1);
        wait_done(6000, "full");
        check_val("full_wb_cnt",    64'(n_wb),       64'd15);
        check_val("full_toggles",   64'(n_toggle),   64'd3);
        check_val("full_busy_cyc",  64'(n_busy),     64'(busy_exp));
        check_val("full_mac_cnt",   64'(n_macen),    64'(mac_exp));
        check_val("full_wreq_cnt",  64'(n_wreq),     64'(mac_exp));
        check_val("full_w_addr",    64'(bus.w_addr), 64'(mac_exp));
        check_val("full_done_lag",  64'(done_cyc - last_wb_cyc), 64'd1);
`ifdef FCL_SCHED_PERF_EN
        check_val("full_perf_cyc",  64'(bus.perf_cycles), 64'(busy_exp));
        check_val("full_perf_stl",  64'(bus.perf_stalls), 64'd0);
`endif

        // 8->4 with alternating w_vld; config written in the same cycle as start
        vld_mode = 1;
        sh_in[0] = 8; sh_out[0] = 4; sh_sh[0] = 3;
        expect_run(1, busy_exp, mac_exp);
        clear_stats();
        bus.cfg_we = 1'b1; bus.cfg_idx = '0; bus.cfg_in_num = NW'(8); bus.cfg_out_num = NW'(4);
        bus.cfg_shift = SW'(3); bus.num_layers = (LW+1)'(1); bus.start = 1'b1;
        tick(1);
        bus.cfg_we = 1'b0; bus.start = 1'b0;
        wait_done(200, "stall");
        vld_mode = 0;
        check_val("stall_mac_cnt",  64'(n_macen), 64'd8);
        check_val("stall_wb_cnt",   64'(n_wb),    64'd1);
        check_val("stall_range",    64'(n_stall == 7 || n_stall == 8), 64'd1);
        check_val("stall_wreq_cnt", 64'(n_wreq),  64'(8 + n_stall));
        check_val("stall_busy_cyc", 64'(n_busy),  64'(busy_exp + n_stall));
`ifdef FCL_SCHED_PERF_EN
        check_val("stall_perf_stl", 64'(bus.perf_stalls), 64'(n_stall));
        check_val("stall_perf_cyc", 64'(bus.perf_cycles), 64'(n_busy));
`endif

        // num_layers == 0: done next cycle, never busy
        clear_stats();
        bus.num_layers = '0; bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        @(negedge clk);
        check_val("zero_done",    64'(bus.done), 64'd1);
        check_val("zero_busy",    64'(bus.busy), 64'd0);
        @(negedge clk);
        check_val("zero_done_end", 64'(bus.done), 64'd0);
        repeat (3) @(negedge clk);
        check_val("zero_busy_cyc", 64'(n_busy), 64'd0);
        tick(1);

        // start and cfg_we while busy are ignored; a second run repeats the first
        cfg_write(0, 8, 8, 2, 1);
        cfg_write(1, 8, 10, 4, 1);
        for (int r = 0; r < 2; r++) begin
            expect_run(2, busy_exp, mac_exp);
            start_run(2);
            tick(4);
            if (r == 0) begin
                bus.num_layers = (LW+1)'(1);
                bus.start = 1'b1;
                cfg_write(0, 3, 4, 9, 0);
                bus.start = 1'b0;
            end
            wait_done(300, "lock");
            check_val("lock_wb_cnt",   64'(n_wb),    64'd5);
            check_val("lock_busy_cyc", 64'(n_busy),  64'(busy_exp));
            check_val("lock_mac_cnt",  64'(n_macen), 64'(mac_exp));
        end

        // in_num == 0 layer: two groups, no weight reads
        cfg_write(0, 0, 8, 1, 1);
        expect_run(1, busy_exp, mac_exp);
        start_run(1);
        wait_done(100, "in0");
        check_val("in0_wreq_cnt", 64'(n_wreq), 64'd0);
        check_val("in0_wb_cnt",   64'(n_wb),   64'd2);
        check_val("in0_busy_cyc", 64'(n_busy), 64'd6);

        // rst during ACC of layer 2 aborts the run
        cfg_write(0, 20, 16, 5, 1);
        cfg_write(1, 16, 16, 6, 1);
        cfg_write(2, 16, 16, 7, 1);
        cfg_write(3, 16, 10, 8, 1);
        expect_run(4, busy_exp, mac_exp);
        start_run(4);
        k = 0;
        while (!(n_wb == 8 && bus.w_req === 1'b1) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_val("rst_reach_l2", 64'(n_wb), 64'd8);
        tick(1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_quiet("rst_mid");
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        wb_before = n_wb;
        repeat (20) @(negedge clk);
        check_val("rst_no_wb",   64'(n_wb),   64'(wb_before));
        check_val("rst_no_done", 64'(n_done), 64'd0);
        tick(1);

        // config table was cleared by rst
        for (int i = 0; i < MAX_LAYERS; i++) begin
            sh_in[i] = 0; sh_out[i] = 0; sh_sh[i] = 0;
        end
        expect_run(1, busy_exp, mac_exp);
        start_run(1);
        wait_done(100, "cleared");
        check_val("cleared_wreq", 64'(n_wreq), 64'd0);
        check_val("cleared_busy", 64'(n_busy), 64'(busy_exp));

        // fresh run after abort starts at layer 0, w_addr 0
        cfg_write(0, 20, 16, 5, 1);
        cfg_write(1, 16, 16, 6, 1);
        cfg_write(2, 16, 16, 7, 1);
        cfg_write(3, 16, 10, 8, 1);
        expect_run(4, busy_exp, mac_exp);
        start_run(4);
        k = 0;
        while (bus.w_req !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_val("rerun_w_req",   64'(bus.w_req),   64'd1);
        check_val("rerun_w_addr",  64'(bus.w_addr),  64'd0);
        check_val("rerun_rd_bank", 64'(bus.rd_bank), 64'd0);
        wait_done(1000, "rerun");
        check_val("rerun_wb_cnt",   64'(n_wb),       64'd15);
        check_val("rerun_w_addr_f", 64'(bus.w_addr), 64'(mac_exp));
        check_val("rerun_busy_cyc", 64'(n_busy),     64'(busy_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
